// File: rtl/theta_step_seq.sv
// Sequential Keccak theta step: column parity C is accumulated one plane per cycle,
// then D is applied to the whole state in a single cycle. A bypass mode forwards the state unchanged.
module theta_step_seq #(
  parameter int W          = 64,
  parameter bit PARITY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_bypass,
  input  logic [25*W-1:0] in_state,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [25*W-1:0] out_state,
  output logic [5*W-1:0]  out_parity
);

  typedef enum logic [1:0] {IDLE, ACCUM, APPLY, DONE} state_e;

  state_e          state_q, state_d;
  logic [25*W-1:0] a_q, res_q, theta_d;
  logic [5*W-1:0]  c_q, par_q, plane, d_vec;
  logic [2:0]      y_q;
  logic            byp_q;
  logic            accept;

  // Rotate a lane left by one bit position; for W=1 this is the identity.
  function automatic logic [W-1:0] rol1(input logic [W-1:0] v);
    rol1 = v;
    for (int z = 0; z < W; z++) rol1[z] = v[(z + W - 1) % W];
  endfunction

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_bypass ? DONE : ACCUM;
      ACCUM:   if (y_q == 3'd4) state_d = APPLY;
      APPLY:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready = rst_n;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Lanes (x=0..4, y) of one plane are contiguous, so a plane is one 5W slice.
  assign plane = a_q[5*W*y_q +: 5*W];

  always_comb begin
    d_vec = '0;
    for (int x = 0; x < 5; x++)
      d_vec[W*x +: W] = c_q[W*((x + 4) % 5) +: W] ^ rol1(c_q[W*((x + 1) % 5) +: W]);
  end

  always_comb begin
    theta_d = a_q;
    for (int y = 0; y < 5; y++)
      theta_d[5*W*y +: 5*W] = a_q[5*W*y +: 5*W] ^ d_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      c_q   <= '0;
      y_q   <= '0;
      byp_q <= 1'b0;
      res_q <= '0;
      par_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_q   <= in_state;
          byp_q <= in_bypass;
          c_q   <= '0;
          y_q   <= '0;
          if (in_bypass) res_q <= in_state;
        end
        ACCUM: begin
          c_q <= c_q ^ plane;
          y_q <= y_q + 3'd1;
        end
        APPLY: begin
          res_q <= theta_d;
          if (PARITY_OUT && !byp_q) par_q <= c_q;
        end
        default: ;
      endcase
    end
  end

  assign out_state  = res_q;
  assign out_parity = par_q;

endmodule
